// File: rtl/booth_mac_accumulator_pkg.sv
// Shared types and saturation bounds for the Booth multiply-accumulate stage.
package booth_mac_accumulator_pkg;

    // Control part of the S1/S2 stage records; the data fields depend on WIDTH.
    typedef struct packed {
        logic last;
        logic valid;
    } stage_ctl_t;

    function automatic logic signed [63:0] sat_max(input int acc_w);
        return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int acc_w);
        return -(64'sd1 <<< (acc_w - 1));
    endfunction

endpackage

// File: rtl/Multi_Booth_signed_even.sv
// Combinational radix-4 Booth signed multiplier; WIDTH must be even.
module Multi_Booth_signed_even #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    logic [WIDTH:0]     b_ext;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] pp;

    assign b_ext = {b, 1'b0};
    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};

    // Each overlapping bit triplet selects a digit in {-2,-1,0,1,2} times a.
    always_comb begin
        p  = '0;
        pp = '0;
        for (int i = 0; i < WIDTH / 2; i++) begin
            case (b_ext[2*i +: 3])
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext << 1;
                3'b100:         pp = -(a_ext << 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            p = p + (pp << (2 * i));
        end
    end

endmodule

// File: rtl/booth_mac_accumulator.sv
// Pipelined signed MAC: S1 operands, Booth multiply, S2 product, saturating
// per-frame accumulator with a valid/ready result register.
module booth_mac_accumulator
    import booth_mac_accumulator_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    stage_ctl_t         s1_ctl, s2_ctl;
    logic [WIDTH-1:0]   s1_a, s1_b;
    logic [2*WIDTH-1:0] prod, s2_prod;
    logic [ACC_W-1:0]   acc, base, acc_nxt;
    logic [ACC_W:0]     sum;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               ovf, ovf_nxt, clamp, frame_start, stall;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall & ~rst;

    Multi_Booth_signed_even #(.WIDTH(WIDTH)) u_mult (
        .a (s1_a),
        .b (s1_b),
        .p (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_ctl <= '0;
            s2_ctl <= '0;
        end else if (!stall) begin
            s1_ctl.valid <= in_valid;
            s1_ctl.last  <= in_last;
            s2_ctl       <= s1_ctl;
        end
    end

    // Data fields need no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_a    <= in_a;
            s1_b    <= in_b;
            s2_prod <= prod;
        end
    end

    // One guard bit: overflow shows up as the top two sum bits disagreeing.
    always_comb begin
        base    = frame_start ? '0 : acc;
        sum     = {base[ACC_W-1], base}
                + {{(ACC_W + 1 - 2*WIDTH){s2_prod[2*WIDTH-1]}}, s2_prod};
        clamp   = sum[ACC_W] ^ sum[ACC_W-1];
        acc_nxt = clamp ? (sum[ACC_W] ? SAT_MIN : SAT_MAX) : sum[ACC_W-1:0];
        cnt_nxt = frame_start ? CNT_W'(1) : ((cnt == CNT_MAX) ? cnt : cnt + 1'b1);
        ovf_nxt = (~frame_start & ovf) | clamp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            frame_start <= 1'b1;
            out_valid   <= 1'b0;
            out_acc     <= '0;
            out_count   <= '0;
            out_ovf     <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (s2_ctl.valid && !stall) begin
                acc         <= acc_nxt;
                cnt         <= cnt_nxt;
                ovf         <= ovf_nxt;
                frame_start <= s2_ctl.last;
                if (s2_ctl.last) begin
                    out_acc   <= acc_nxt;
                    out_count <= cnt_nxt;
                    out_ovf   <= ovf_nxt;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Directed bench for booth_mac_accumulator; a second instance uses ACC_W=20
// so saturation is reachable with 10-bit operands.
module tb_booth_mac_accumulator;

    localparam logic [9:0] NEG512 = 10'h200;
    localparam logic [9:0] POS511 = 10'h1FF;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_ready20;
    logic [9:0]  in_a, in_b;
    logic        in_last, out_ready;
    logic        out_valid, out_valid20;
    logic [31:0] out_acc;
    logic [19:0] out_acc20;
    logic [15:0] out_count, out_count20;
    logic        out_ovf, out_ovf20;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   acc;
        int   cnt;
        logic ovf;
    } res_t;

    res_t res_q[$];
    res_t res20_q[$];
    res_t mon_r;

    always #5 clk = ~clk;

    booth_mac_accumulator #(.WIDTH(10), .ACC_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
    );

    booth_mac_accumulator #(.WIDTH(10), .ACC_W(20), .CNT_W(16)) dut20 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready20),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid20), .out_ready(out_ready),
        .out_acc(out_acc20), .out_count(out_count20), .out_ovf(out_ovf20)
    );

    // Record every result that will transfer on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_ready) begin
            if (out_valid) begin
                mon_r.acc = int'($signed(out_acc));
                mon_r.cnt = int'(out_count);
                mon_r.ovf = out_ovf;
                res_q.push_back(mon_r);
            end
            if (out_valid20) begin
                mon_r.acc = int'($signed(out_acc20));
                mon_r.cnt = int'(out_count20);
                mon_r.ovf = out_ovf20;
                res20_q.push_back(mon_r);
            end
        end
    end

    task automatic send(input logic [9:0] a, input logic [9:0] b, input logic last);
        logic ok;
        ok = 1'b0;
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_accept: in_ready never high for a=%0d b=%0d", $signed(a), $signed(b));
        end
    endtask

    task automatic wait_res(input int n, input bit use20);
        for (int t = 0; t < 100; t++) begin
            if ((use20 ? res20_q.size() : res_q.size()) >= n) break;
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_acc !== 32'd0 || out_count !== 16'd0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b acc=%0d cnt=%0d ovf=%0b, expected all 0",
                     out_valid, out_acc, out_count, out_ovf);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b expected 0", in_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready: got %0b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        res_q.delete();
        send(10'd3, 10'd4, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_latency_early: cycle %0d out_valid=%0b expected 0", c, out_valid);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || $signed(out_acc) !== 32'sd12 || out_count !== 16'd1 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL single_result: got v=%0b acc=%0d cnt=%0d ovf=%0b expected v=1 acc=12 cnt=1 ovf=0",
                     out_valid, $signed(out_acc), out_count, out_ovf);
        end
        wait_res(1, 1'b0);
        checks++;
        if (res_q.size() != 1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_count: got %0d results v=%0b expected 1 result, v=0", res_q.size(), out_valid);
        end
    endtask

    task automatic test_corner();
        res_q.delete();
        for (int k = 0; k < 4; k++) send(NEG512, NEG512, k == 3);
        send(NEG512, POS511, 1'b1);
        wait_res(2, 1'b0);
        checks++;
        if (res_q.size() != 2) begin
            errors++;
            $display("FAIL corner_count: got %0d results expected 2", res_q.size());
        end else begin
            checks++;
            if (res_q[0].acc != 1048576 || res_q[0].cnt != 4 || res_q[0].ovf !== 1'b0) begin
                errors++;
                $display("FAIL corner_sq: got acc=%0d cnt=%0d ovf=%0b expected 1048576/4/0",
                         res_q[0].acc, res_q[0].cnt, res_q[0].ovf);
            end
            checks++;
            if (res_q[1].acc != -261632 || res_q[1].cnt != 1 || res_q[1].ovf !== 1'b0) begin
                errors++;
                $display("FAIL corner_mixed: got acc=%0d cnt=%0d ovf=%0b expected -261632/1/0",
                         res_q[1].acc, res_q[1].cnt, res_q[1].ovf);
            end
        end
    endtask

    task automatic test_saturation();
        res_q.delete();
        res20_q.delete();
        for (int k = 0; k < 3; k++) send(NEG512, NEG512, k == 2);
        send(10'd1, 10'd1, 1'b1);
        wait_res(2, 1'b1);
        checks++;
        if (res20_q.size() != 2 || res_q.size() != 2) begin
            errors++;
            $display("FAIL sat_count: got %0d/%0d results expected 2/2", res20_q.size(), res_q.size());
        end else begin
            checks++;
            if (res20_q[0].acc != 524287 || res20_q[0].cnt != 3 || res20_q[0].ovf !== 1'b1) begin
                errors++;
                $display("FAIL sat_clamp: got acc=%0d cnt=%0d ovf=%0b expected 524287/3/1",
                         res20_q[0].acc, res20_q[0].cnt, res20_q[0].ovf);
            end
            checks++;
            if (res20_q[1].acc != 1 || res20_q[1].cnt != 1 || res20_q[1].ovf !== 1'b0) begin
                errors++;
                $display("FAIL sat_ovf_clear: got acc=%0d cnt=%0d ovf=%0b expected 1/1/0",
                         res20_q[1].acc, res20_q[1].cnt, res20_q[1].ovf);
            end
            checks++;
            if (res_q[0].acc != 786432 || res_q[0].ovf !== 1'b0) begin
                errors++;
                $display("FAIL sat_wide_acc: got acc=%0d ovf=%0b expected 786432/0",
                         res_q[0].acc, res_q[0].ovf);
            end
        end
    endtask

    task automatic test_backpressure();
        res_q.delete();
        fork
            begin
                for (int k = 1; k <= 6; k++) send(10'(k), 10'd1, 1'b1);
            end
            begin
                logic [31:0] held;
                bit          held_set;
                held_set  = 1'b0;
                held      = '0;
                out_ready = 1'b0;
                for (int c = 0; c < 6; c++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        checks++;
                        if (in_ready !== 1'b0) begin
                            errors++;
                            $display("FAIL bp_in_ready: got %0b expected 0 while stalled", in_ready);
                        end
                        if (!held_set) begin
                            held     = out_acc;
                            held_set = 1'b1;
                        end else begin
                            checks++;
                            if (out_acc !== held) begin
                                errors++;
                                $display("FAIL bp_stable: got acc=%0d expected %0d", out_acc, held);
                            end
                        end
                    end
                end
                checks++;
                if (out_valid !== 1'b1 || out_acc !== 32'd1) begin
                    errors++;
                    $display("FAIL bp_held_valid: got v=%0b acc=%0d expected v=1 acc=1", out_valid, out_acc);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_res(6, 1'b0);
        checks++;
        if (res_q.size() != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d results expected 6", res_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (res_q[k].acc != k + 1 || res_q[k].cnt != 1) begin
                    errors++;
                    $display("FAIL bp_order: result %0d got acc=%0d cnt=%0d expected %0d/1",
                             k, res_q[k].acc, res_q[k].cnt, k + 1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        res_q.delete();
        send(10'd2, 10'd3, 1'b1);
        send(10'(-5), 10'd7, 1'b0);
        send(10'd1, 10'd1, 1'b1);
        wait_res(2, 1'b0);
        checks++;
        if (res_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d results expected 2", res_q.size());
        end else begin
            checks++;
            if (res_q[0].acc != 6 || res_q[0].cnt != 1) begin
                errors++;
                $display("FAIL b2b_first: got acc=%0d cnt=%0d expected 6/1", res_q[0].acc, res_q[0].cnt);
            end
            checks++;
            if (res_q[1].acc != -34 || res_q[1].cnt != 2) begin
                errors++;
                $display("FAIL b2b_second: got acc=%0d cnt=%0d expected -34/2", res_q[1].acc, res_q[1].cnt);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        res_q.delete();
        send(10'd5, 10'd5, 1'b0);
        send(10'd7, 10'd7, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_in_ready: got %0b expected 0", in_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        send(10'd1, 10'd1, 1'b1);
        wait_res(1, 1'b0);
        checks++;
        if (res_q.size() != 1) begin
            errors++;
            $display("FAIL midrst_count: got %0d results expected 1", res_q.size());
        end else begin
            checks++;
            if (res_q[0].acc != 1 || res_q[0].cnt != 1 || res_q[0].ovf !== 1'b0) begin
                errors++;
                $display("FAIL midrst_result: got acc=%0d cnt=%0d ovf=%0b expected 1/1/0",
                         res_q[0].acc, res_q[0].cnt, res_q[0].ovf);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_corner();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
